// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller with its datapath.
// One ADDSUB/SHIFT pair per multiplier bit, then a single DONE cycle.
module booth_seq_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               op_add,
    output logic               op_sub,
    output logic               op_shift
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned AW = WIDTH + 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDSUB = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   a, a_nx;
    logic [WIDTH-1:0] q, q_nx;
    logic            q1, q1_nx;
    logic [WIDTH-1:0] m, m_nx;
    logic [CW-1:0]   count, count_nx;
    logic            busy_nx, done_nx, op_add_nx, op_sub_nx, op_shift_nx;
    logic [PW-1:0]   product_nx;
    logic [AW-1:0]   m_ext;

    // Sign extension keeps M = -2^(WIDTH-1) exact in the accumulator.
    assign m_ext = {m[WIDTH-1], m};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a        <= '0;
            q        <= '0;
            q1       <= 1'b0;
            m        <= '0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            op_add   <= 1'b0;
            op_sub   <= 1'b0;
            op_shift <= 1'b0;
            product  <= '0;
        end else begin
            state    <= state_nx;
            a        <= a_nx;
            q        <= q_nx;
            q1       <= q1_nx;
            m        <= m_nx;
            count    <= count_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            op_add   <= op_add_nx;
            op_sub   <= op_sub_nx;
            op_shift <= op_shift_nx;
            product  <= product_nx;
        end
    end

    // Next state and datapath; strobes are precomputed for the cycle being entered.
    always_comb begin
        state_nx = state;
        a_nx     = a;
        q_nx     = q;
        q1_nx    = q1;
        m_nx     = m;
        count_nx = count;

        case (state)
            IDLE: begin
                if (start) begin
                    m_nx     = multiplicand;
                    q_nx     = multiplier;
                    a_nx     = '0;
                    q1_nx    = 1'b0;
                    count_nx = CW'(WIDTH);
                    state_nx = ADDSUB;
                end
            end
            ADDSUB: begin
                case ({q[0], q1})
                    2'b10:   a_nx = a - m_ext;
                    2'b01:   a_nx = a + m_ext;
                    default: a_nx = a;
                endcase
                state_nx = SHIFT;
            end
            SHIFT: begin
                {a_nx, q_nx, q1_nx} = {a[AW-1], a, q};
                count_nx = count - CW'(1);
                state_nx = (count_nx == '0) ? DONE : ADDSUB;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx     = (state_nx != IDLE);
        done_nx     = (state_nx == DONE);
        op_sub_nx   = (state_nx == ADDSUB) && ({q_nx[0], q1_nx} == 2'b10);
        op_add_nx   = (state_nx == ADDSUB) && ({q_nx[0], q1_nx} == 2'b01);
        op_shift_nx = (state_nx == SHIFT);
        product_nx  = (state_nx == DONE) ? {a_nx[WIDTH-1:0], q_nx} : product;
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl (WIDTH=4): table vectors, corner sequences, full sweep.
module tb_booth_seq_ctrl;

    localparam int unsigned W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           op_add;
    logic           op_sub;
    logic           op_shift;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] sb[$];

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] prod;
    } vec_t;

    vec_t tbl[8];

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .op_add       (op_add),
        .op_sub       (op_sub),
        .op_shift     (op_shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Strobe exclusivity and quiet strobes outside the arithmetic states.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("op_exclusive", 32'($countones({op_add, op_sub, op_shift}) <= 1), 32'd1);
            if (!busy || done)
                chk("op_quiet_idle_done", {29'd0, op_add, op_sub, op_shift}, 32'd0);
        end
    end

    // Call at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic [2*W-1:0] exp);
        int n_add = 0, n_sub = 0, n_shift = 0, exp_add = 0, exp_sub = 0;
        int done_cyc = 0, busy_cyc = 0;
        logic prev = 1'b0;
        logic [2*W-1:0] held = '0;
        for (int i = 0; i < int'(W); i++) begin
            if ({q[i], prev} == 2'b10) exp_sub++;
            if ({q[i], prev} == 2'b01) exp_add++;
            prev = q[i];
        end
        sb.push_back(exp);
        start = 1'b1;
        multiplicand = m;
        multiplier = q;
        @(posedge clk);
        for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                chk("accept_busy", 32'(busy), 32'd1);
                start = 1'b0;
                multiplicand = ~m;
                multiplier = m ^ q ^ 4'h5;
            end
            if (cyc == 3) start = 1'b1;
            if (cyc == 4) start = 1'b0;
            busy_cyc += int'(busy);
            n_add += int'(op_add);
            n_sub += int'(op_sub);
            n_shift += int'(op_shift);
            if (done) begin
                done_cyc = cyc;
                held = product;
                if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else chk("product", 32'(product), 32'(sb.pop_front()));
            end
        end
        if (done_cyc == 0) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", 32'(done_cyc), 32'(2 * W + 1));
            chk("busy_cycles", 32'(busy_cyc), 32'(2 * W + 1));
            chk("shift_count", 32'(n_shift), 32'(W));
            chk("add_count", 32'(n_add), 32'(exp_add));
            chk("sub_count", 32'(n_sub), 32'(exp_sub));
        end
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("product_hold", 32'(product), 32'(held));
    endtask

    initial begin
        logic [2*W-1:0] ref_p;
        logic [W-1:0]   mr, qr;
        int dcyc[$];
        int off;

        tbl[0] = '{4'h3, 4'h2, 8'h06};
        tbl[1] = '{4'h8, 4'h8, 8'h40};
        tbl[2] = '{4'h8, 4'h7, 8'hC8};
        tbl[3] = '{4'h7, 4'hF, 8'hF9};
        tbl[4] = '{4'h0, 4'h5, 8'h00};
        tbl[5] = '{4'h5, 4'hD, 8'hF1};
        tbl[6] = '{4'h9, 4'h3, 8'hEB};
        tbl[7] = '{4'hF, 4'hF, 8'h01};

        rst_n = 1'b0;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_ops", {29'd0, op_add, op_sub, op_shift}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(tbl[i].m, tbl[i].q, tbl[i].prod);

        // Start held high: back-to-back operations every 10 cycles.
        start = 1'b1;
        multiplicand = 4'h2;
        multiplier = 4'h3;
        repeat (3) sb.push_back(8'h06);
        @(posedge clk);
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(negedge clk);
            if (done) begin
                dcyc.push_back(cyc);
                if (sb.size() == 0) chk("b2b_unexpected_done", 32'd1, 32'd0);
                else chk("b2b_product", 32'(product), 32'(sb.pop_front()));
            end
            if (cyc == 30) start = 1'b0;
        end
        chk("b2b_done_count", 32'(dcyc.size()), 32'd3);
        if (dcyc.size() == 3) begin
            chk("b2b_first", 32'(dcyc[0]), 32'd9);
            chk("b2b_gap1", 32'(dcyc[1] - dcyc[0]), 32'd10);
            chk("b2b_gap2", 32'(dcyc[2] - dcyc[1]), 32'd10);
        end
        repeat (12) @(negedge clk);
        chk("b2b_idle", 32'(busy), 32'd0);

        // Reset during the third SHIFT cycle aborts without a done pulse.
        start = 1'b1;
        multiplicand = 4'h5;
        multiplier = 4'h3;
        @(posedge clk);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
        end
        chk("third_shift", 32'(op_shift), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_ops", {29'd0, op_add, op_sub, op_shift}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        run_op(4'hF, 4'hF, 8'h01);

        // All 256 operand pairs against a signed reference, starting at a random offset.
        off = int'($urandom_range(0, 255));
        for (int k = 0; k < 256; k++) begin
            mr = W'((k + off) >> 4);
            qr = W'(k + off);
            ref_p = (2*W)'($signed(mr) * $signed(qr));
            run_op(mr, qr, ref_p);
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
